// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that drains a synchronous FIFO: pops one byte per frame
// and shifts it out LSB first between a low start bit and a high stop bit.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_W) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_PRE  = TW'(CLKS_PER_BIT - 2);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;

  state_t            state;
  logic [TW-1:0]     timer;
  logic [IW-1:0]     bit_idx;
  logic [DATA_W-1:0] shift;

  // The pop request must drop in the same cycle reset is asserted.
  assign fifo_rd_en = (state == IDLE) && enable && !fifo_empty && !rst;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      frame_done <= 1'b0;
      shift      <= '0;
      timer      <= '0;
      bit_idx    <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (fifo_rd_en) state <= FETCH;
        end
        // FIFO read data is valid here, one cycle after the pop.
        FETCH: begin
          shift   <= fifo_data;
          timer   <= '0;
          bit_idx <= '0;
          tx      <= 1'b0;
          state   <= START;
        end
        START: begin
          if (timer == T_LAST) begin
            timer <= '0;
            tx    <= shift[0];
            state <= DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        // tx is loaded one bit ahead so it changes exactly on the bit boundary.
        DATA: begin
          if (timer == T_LAST) begin
            timer   <= '0;
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == I_LAST) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx <= shift[1];
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STOP: begin
          if (timer == T_LAST) begin
            timer <= '0;
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
            if (timer == T_PRE) frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomized directed bench for fifo_uart_tx: a queue models the FIFO and a
// frame-timing model predicts tx/busy/frame_done/fifo_rd_en every cycle.
module tb_fifo_uart_tx;
  localparam int C  = 4;
  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       rst, enable, fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en, tx, busy, frame_done;

  fifo_uart_tx #(.CLKS_PER_BIT(C), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int         checks = 0, errors = 0;
  int         cyc = 0, m_start = 0, m_end = -1;
  int         pops = 0, frames = 0, fd_cyc = -1;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] q[$];
  int         pop_cyc[$];
  logic       tx_log [0:4095];
  logic [7:0] sent [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  // Frame model: pop at cycle N, start bit from N+2, each bit C cycles wide.
  function automatic logic exp_tx(input int t);
    int bp;
    if (t <= m_start + 1 || t > m_end) return 1'b1;
    bp = (t - m_start - 2) / C;
    if (bp == 0) return 1'b0;
    if (bp <= 8) return m_byte[bp-1];
    return 1'b1;
  endfunction

  task automatic check_outputs();
    chk("tx", 32'(tx), 32'(exp_tx(cyc)));
    chk("busy", 32'(busy), 32'(cyc > m_start && cyc <= m_end));
    chk("frame_done", 32'(frame_done), 32'(cyc == m_end));
  endtask

  task automatic tick();
    logic rd, em, exp_rd;
    @(negedge clk);
    rd = fifo_rd_en;
    em = fifo_empty;
    exp_rd = !rst && enable && (q.size() > 0) && (cyc > m_end);
    chk("rd_en", 32'(rd), 32'(exp_rd));
    chk("rd_while_empty", 32'(rd && em), 32'(0));
    if (exp_rd) begin
      m_start = cyc;
      m_end   = cyc + 1 + 10 * C;
      m_byte  = q[0];
    end
    if (rst) m_end = -1;
    if (rd) begin
      pops++;
      pop_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rd && q.size() > 0) fifo_data = q.pop_front();
    fifo_empty = (q.size() == 0);
    if (cyc < 4096) tx_log[cyc] = tx;
    if (frame_done) begin
      frames++;
      fd_cyc = cyc;
    end
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_counts();
    pops = 0;
    frames = 0;
    pop_cyc.delete();
  endtask

  function automatic logic [7:0] decode(input int p);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[k] = tx_log[p + 2 + (k + 1) * C + C / 2];
    return b;
  endfunction

  initial begin
    logic [9:0] a5_bits;
    int         p, target;
    a5_bits    = 10'b11_0100_1010;  // bit i = frame bit i for 8'hA5
    rst        = 1'b1;
    enable     = 1'b1;
    fifo_data  = 8'h00;
    fifo_empty = 1'b1;
    push(8'hA5);

    // Reset held three cycles with the FIFO non-empty.
    @(posedge clk);
    #1;
    cyc = 0;
    tx_log[0] = tx;
    check_outputs();
    chk("reset_rd_en", 32'(fifo_rd_en), 32'(0));
    run(2);
    rst = 1'b0;

    // Single byte 8'hA5.
    clear_counts();
    run(60);
    chk("single_pops", 32'(pops), 32'(1));
    chk("single_frames", 32'(frames), 32'(1));
    p = (pop_cyc.size() > 0) ? pop_cyc[0] : 0;
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < C; j++)
        chk("a5_seq", 32'(tx_log[p + 2 + i * C + j]), 32'(a5_bits[i]));
    chk("single_done_delay", 32'(fd_cyc - p), 32'(41));

    // Burst of 16 random bytes, back to back.
    clear_counts();
    for (int i = 0; i < 16; i++) begin
      sent[i] = 8'($urandom_range(0, 255));
      push(sent[i]);
    end
    run(16 * 42 + 20);
    chk("burst_pops", 32'(pops), 32'(16));
    chk("burst_frames", 32'(frames), 32'(16));
    for (int i = 0; i < 16 && i < pop_cyc.size(); i++) begin
      chk("burst_byte", 32'(decode(pop_cyc[i])), 32'(sent[i]));
      if (i > 0) chk("burst_period", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'(42));
    end
    chk("burst_idle_busy", 32'(busy), 32'(0));

    // Enable gating, then enable dropped mid-frame.
    clear_counts();
    enable = 1'b0;
    push(8'h3C);
    push(8'($urandom_range(0, 255)));
    run(100);
    chk("gate_no_pop", 32'(pops), 32'(0));
    enable = 1'b1;
    run(20);
    enable = 1'b0;
    run(60);
    chk("gate_pops", 32'(pops), 32'(1));
    chk("gate_frames", 32'(frames), 32'(1));
    chk("gate_left", 32'(q.size()), 32'(1));
    if (pop_cyc.size() > 0) chk("gate_byte", 32'(decode(pop_cyc[0])), 32'(8'h3C));
    enable = 1'b1;
    run(60);

    // Empty FIFO with enable high.
    clear_counts();
    run(20);
    chk("empty_pops", 32'(pops), 32'(0));
    chk("empty_tx", 32'(tx), 32'(1));

    // Reset during data bit 3 of 8'hFF.
    clear_counts();
    push(8'hFF);
    push(8'h5A);
    tick();
    target = (pop_cyc.size() > 0) ? pop_cyc[0] + 2 + 4 * C + 1 : cyc + 10;
    for (int i = 0; i < 200 && cyc < target; i++) tick();
    chk("rstmid_reach", 32'(cyc), 32'(target));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_tx", 32'(tx), 32'(1));
    chk("rstmid_busy", 32'(busy), 32'(0));
    run(60);
    chk("rstmid_pops", 32'(pops), 32'(2));
    chk("rstmid_frames", 32'(frames), 32'(1));
    if (pop_cyc.size() > 1) chk("rstmid_byte", 32'(decode(pop_cyc[1])), 32'(8'h5A));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

FIFO-draining UART transmitter: the read-side consumer for the team's 8-bit synchronous `fifo`. When enabled and the FIFO is not empty, it pops one byte and shifts it out on a single serial line as an 8N1 frame: start bit, 8 data bits LSB first, one stop bit. It then returns to idle and pops the next byte. It connects directly to the FIFO's `read_en`, `empty` and `data_out` ports.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal values ≥ 2.
- `DATA_W`, 8: byte width; must match the FIFO data width.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset; one clock, one synchronous active-high reset, no other clock domains.
- `enable`  in  1  permits starting new frames; sampled only in IDLE.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_data`  in  DATA_W  FIFO `data_out`; valid the cycle after a read is accepted.
- `fifo_rd_en`  out  1  FIFO `read_en`; one-cycle pop request.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high whenever state ≠ IDLE.
- `frame_done`  out  1  one-cycle pulse in the last cycle of the stop bit.

## Operation
- States: IDLE, FETCH, START, DATA, STOP.
- `fifo_rd_en` is combinational: (state==IDLE) && enable && !fifo_empty && !rst. It is never high in any other state.
- IDLE: `tx`=1. If `fifo_rd_en`, go to FETCH at the next edge; otherwise remain in IDLE.
- FETCH: lasts one cycle. Capture `fifo_data` into the shift register, clear the bit-timer and bit index, then go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: `tx` = shift[0]. Every CLKS_PER_BIT cycles, shift right by 1 and increment the bit index. After DATA_W bits, go to STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles. `frame_done`=1 in the final cycle, then go to IDLE.
- `tx` is a registered output, driven from the state and shift register with no combinational glitch path.
- Bit timer: $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1, and wraps to 0 on each bit boundary.
- Bit index: $clog2(DATA_W)+1 bits; it never wraps inside a frame.
- `enable` deasserted mid-frame: the current frame completes normally, and no new pop occurs while `enable`=0.
- `fifo_empty` is ignored outside IDLE. The block never pops when `fifo_empty`=1, so there is no underflow.
- Reset mid-frame: at the next edge, state=IDLE and `tx`=1. The popped byte is discarded and not retransmitted.

## Timing
- Reset values: `tx`=1, `busy`=0, `frame_done`=0, `fifo_rd_en`=0, shift register=0, counters=0.
- Cycle N: IDLE with `fifo_rd_en`=1.
  - N+1: FETCH, `busy`=1, `tx` still 1.
  - N+2: `tx` falls (first start-bit cycle).
- Data bit k occupies cycles N+2+(k+1)·CLKS_PER_BIT through N+1+(k+2)·CLKS_PER_BIT.
- Stop bit ends at cycle N+1+10·CLKS_PER_BIT, where `frame_done`=1. N+2+10·CLKS_PER_BIT is IDLE.
- Back-to-back frames with a non-empty FIFO: `tx` stays high for CLKS_PER_BIT+2 cycles between frames (stop, IDLE, FETCH).
- Frame period: 10·CLKS_PER_BIT+2 cycles.
- Exactly one `fifo_rd_en` pulse is issued per frame.

## Test plan
- Reset: CLKS_PER_BIT=4, hold `rst`=1 for 3 cycles with the FIFO non-empty → `tx`=1, `busy`=0, `fifo_rd_en`=0 throughout.
- Single byte: FIFO holds 8'hA5, `enable`=1 →
  - one `fifo_rd_en` pulse;
  - `tx` sequence, 4 cycles per bit: 0,1,0,1,0,0,1,0,1,1;
  - `frame_done` 41 cycles after the pulse;
  - `busy` falls next cycle.
- Burst: write 16 random bytes into the FIFO (0x00..0xFF range), `enable`=1 →
  - 16 frames, each period 42 cycles;
  - decoded bytes match in write order;
  - `fifo_rd_en` never coincides with `fifo_empty`=1;
  - idle afterwards.
- Enable gating: `enable`=0 with FIFO holding 8'h3C → no pop and `tx`=1 for 100 cycles. Drop `enable` mid-frame → that frame completes, and no further pop follows.
- Empty FIFO: `enable`=1, `fifo_empty`=1 → `fifo_rd_en`=0, `busy`=0, `tx`=1.
- Reset mid-frame: assert `rst` during data bit 3 of 8'hFF → the next cycle shows IDLE, `tx`=1. After release with a non-empty FIFO, the next frame starts cleanly with the next byte.
